// File: rtl/opti_pkg.sv
// Shared definitions for the SOS time-multiplexing scheduler.
//   - default cascade depth and sample width
//   - Q2.14 reference constants
//   - scheduler FSM state encoding
package opti_pkg;

   localparam int DEF_NUM_SECTIONS = 6;
   localparam int DEF_DW           = 16;
   localparam int STAGE_W          = 3;    // section index width (up to 8 sections)

   // Q2.14: 1 sign bit, 1 integer bit, 14 fraction bits
   localparam logic [15:0] Q14_ZERO = 16'h0000;
   localparam logic [15:0] Q14_HALF = 16'h2000;
   localparam logic [15:0] Q14_ONE  = 16'h4000;
   localparam logic [15:0] Q14_MAX  = 16'h7FFF;
   localparam logic [15:0] Q14_MIN  = 16'h8000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } sched_state_t;

endpackage

// File: rtl/opti_sched_hist.sv
// Direct-form-I history register file for the SOS scheduler.
// Entry j=0 holds the cascade input, entry j=k+1 the output of section k.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   clr                 synchronous zero of cur/h1/h2
//   in_we, in_data      write cur[0] (new cascade input)
//   res_we, res_data    write cur[rd_k+1] (section result)
//   shift               h2<=h1, h1<=cur for every entry at once
//   rd_k                section being served
//   x0,x1,x2            cur/h1/h2 of entry rd_k (section input)
//   y1,y2               h1/h2 of entry rd_k+1 (section output history)
module opti_sched_hist
   import opti_pkg::*;
#(
   parameter int NUM_SECTIONS = DEF_NUM_SECTIONS,
   parameter int DW           = DEF_DW
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               in_we,
   input  logic [DW-1:0]      in_data,
   input  logic               res_we,
   input  logic [DW-1:0]      res_data,
   input  logic               shift,
   input  logic [STAGE_W-1:0] rd_k,
   output logic [DW-1:0]      x0,
   output logic [DW-1:0]      x1,
   output logic [DW-1:0]      x2,
   output logic [DW-1:0]      y1,
   output logic [DW-1:0]      y2
);

   logic [NUM_SECTIONS:0][DW-1:0] cur, h1, h2;

   // Shift and writes never coincide: writes happen in IDLE/WAIT, the
   // shift only in DONE, and the clear only in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur <= '0;
         h1  <= '0;
         h2  <= '0;
      end else if (clr) begin
         cur <= '0;
         h1  <= '0;
         h2  <= '0;
      end else if (shift) begin
         h2 <= h1;
         h1 <= cur;
      end else begin
         if (in_we)
            cur[0] <= in_data;
         for (int j = 1; j <= NUM_SECTIONS; j++)
            if (res_we && (int'(rd_k) + 1 == j))
               cur[j] <= res_data;
      end
   end

   // Mux-based read keeps the index width independent of NUM_SECTIONS.
   always_comb begin
      x0 = '0;
      x1 = '0;
      x2 = '0;
      y1 = '0;
      y2 = '0;
      for (int j = 0; j <= NUM_SECTIONS; j++) begin
         if (int'(rd_k) == j) begin
            x0 = cur[j];
            x1 = h1[j];
            x2 = h2[j];
         end
         if (int'(rd_k) + 1 == j) begin
            y1 = h1[j];
            y2 = h2[j];
         end
      end
   end

endmodule

// File: rtl/opti_sos_scheduler.sv
// Runs every biquad section of an IIR cascade on one shared SOS engine.
// One sample is accepted in IDLE, each section is issued in turn (ISSUE),
// its result collected (WAIT), and the cascade output emitted in DONE,
// where all history advances together.
// Optional feature macro: OPTI_SCHED_WDOG_EN (WAIT watchdog + sticky err).
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   data_in, data_in_valid        input sample handshake (held by source)
//   in_ready                      high in IDLE
//   hist_clr                      flush history / clear err, IDLE only
//   eng_start, eng_stage          engine launch pulse and section index
//   eng_x0..eng_x2, eng_y1, eng_y2  DF-I operands for the section
//   eng_done, eng_y               engine completion and result
//   data_out, data_out_valid      cascade output and one-cycle strobe
//   busy                          not IDLE
//   err                           sticky watchdog error
module opti_sos_scheduler
   import opti_pkg::*;
#(
   parameter int NUM_SECTIONS = DEF_NUM_SECTIONS,
   parameter int DW           = DEF_DW,
   parameter int WDOG_CYCLES  = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [DW-1:0]      data_in,
   input  logic               data_in_valid,
   output logic               in_ready,
   input  logic               hist_clr,
   output logic               eng_start,
   output logic [STAGE_W-1:0] eng_stage,
   output logic [DW-1:0]      eng_x0,
   output logic [DW-1:0]      eng_x1,
   output logic [DW-1:0]      eng_x2,
   output logic [DW-1:0]      eng_y1,
   output logic [DW-1:0]      eng_y2,
   input  logic               eng_done,
   input  logic [DW-1:0]      eng_y,
   output logic [DW-1:0]      data_out,
   output logic               data_out_valid,
   output logic               busy,
   output logic               err
);

   localparam logic [STAGE_W-1:0] K_LAST = STAGE_W'(NUM_SECTIONS - 1);

   sched_state_t       state, state_nxt;
   logic [STAGE_W-1:0] k;
   logic               accept, res_we, shift, clr;
   logic               wdog_hit;

   opti_sched_hist #(
      .NUM_SECTIONS (NUM_SECTIONS),
      .DW           (DW)
   ) u_hist (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .in_we    (accept),
      .in_data  (data_in),
      .res_we   (res_we),
      .res_data (eng_y),
      .shift    (shift),
      .rd_k     (k),
      .x0       (eng_x0),
      .x1       (eng_x1),
      .x2       (eng_x2),
      .y1       (eng_y1),
      .y2       (eng_y2)
   );

   assign in_ready       = (state == S_IDLE);
   assign busy           = (state != S_IDLE);
   assign data_out_valid = (state == S_DONE);
   assign eng_stage      = k;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      eng_start = 1'b0;
      accept    = 1'b0;
      res_we    = 1'b0;
      shift     = 1'b0;
      clr       = 1'b0;
      case (state)
         S_IDLE: begin
            if (hist_clr) begin
               clr = 1'b1;
            end else if (data_in_valid) begin
               accept    = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            eng_start = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (eng_done) begin
               res_we    = 1'b1;
               state_nxt = (k == K_LAST) ? S_DONE : S_ISSUE;
            end else if (wdog_hit) begin
               state_nxt = S_IDLE;
            end
         end
         S_DONE: begin
            shift     = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // data_out is loaded from the last section's result so that it is
   // already valid in the DONE cycle alongside data_out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k        <= '0;
         data_out <= '0;
      end else begin
         if (accept)
            k <= '0;
         else if (res_we) begin
            if (k == K_LAST) data_out <= eng_y;
            else             k        <= k + STAGE_W'(1);
         end
      end
   end

`ifdef OPTI_SCHED_WDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);

   logic [WW-1:0] wdog_cnt;

   // Fires on the WDOG_CYCLES-th consecutive WAIT cycle without eng_done.
   assign wdog_hit = (state == S_WAIT) && !eng_done &&
                     (wdog_cnt == WW'(WDOG_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_cnt <= '0;
         err      <= 1'b0;
      end else begin
         if (state == S_WAIT && !eng_done) wdog_cnt <= wdog_cnt + WW'(1);
         else                              wdog_cnt <= '0;
         if (wdog_hit)  err <= 1'b1;
         else if (clr)  err <= 1'b0;
      end
   end
`else
   logic unused_wdog;
   assign unused_wdog = ^WDOG_CYCLES;
   assign wdog_hit    = 1'b0;
   assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_opti_sos_scheduler.sv
// Directed bench for opti_sos_scheduler with an identity engine (eng_y =
// eng_x0, latency L=2), N=6 sections. Watchdog scenario runs only when
// OPTI_SCHED_WDOG_EN is defined (instance uses WDOG_CYCLES=8).
module tb_opti_sos_scheduler;

   localparam int N = 6;
   localparam int L = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] data_in;
   logic        data_in_valid;
   logic        in_ready;
   logic        hist_clr;
   logic        eng_start;
   logic [2:0]  eng_stage;
   logic [15:0] eng_x0, eng_x1, eng_x2, eng_y1, eng_y2;
   logic        eng_done;
   logic [15:0] eng_y;
   logic [15:0] data_out;
   logic        data_out_valid;
   logic        busy;
   logic        err;

   opti_sos_scheduler #(.NUM_SECTIONS(N), .DW(16), .WDOG_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .data_in(data_in), .data_in_valid(data_in_valid), .in_ready(in_ready),
      .hist_clr(hist_clr),
      .eng_start(eng_start), .eng_stage(eng_stage),
      .eng_x0(eng_x0), .eng_x1(eng_x1), .eng_x2(eng_x2),
      .eng_y1(eng_y1), .eng_y2(eng_y2),
      .eng_done(eng_done), .eng_y(eng_y),
      .data_out(data_out), .data_out_valid(data_out_valid),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // identity engine, done L cycles after start
   logic eng_mute;
   logic epend;
   int   ecnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         epend <= 1'b0; ecnt <= 0; eng_done <= 1'b0; eng_y <= '0;
      end else begin
         eng_done <= 1'b0;
         if (epend) begin
            if (ecnt == L - 1) begin
               eng_done <= 1'b1; eng_y <= eng_x0; epend <= 1'b0;
            end else ecnt <= ecnt + 1;
         end else if (eng_start && !eng_mute) begin
            epend <= 1'b1; ecnt <= 1;
         end
      end
   end

   int n_vec = 0;
   int n_miss = 0;

   // capture of one run
   int          a;
   int          n_iss, n_out, viol;
   logic [2:0]  stg [24];
   int          icy [24];
   logic [15:0] cx0 [24], cx1 [24], cx2 [24], cy1 [24], cy2 [24];
   int          ocy [4];
   logic [15:0] oval [4];

   task automatic run(input logic [15:0] v, input int hold, input bit clr_busy);
      int guard;
      n_iss = 0; n_out = 0; viol = 0; guard = 0;
      @(negedge clk);
      data_in = v; data_in_valid = 1'b1; a = cyc;
      do begin
         @(negedge clk);
         guard++;
         if (cyc - a >= hold) data_in_valid = 1'b0;
         hist_clr = clr_busy && !in_ready;
         if (eng_start && n_iss < 24) begin
            stg[n_iss] = eng_stage; icy[n_iss] = cyc;
            cx0[n_iss] = eng_x0; cx1[n_iss] = eng_x1; cx2[n_iss] = eng_x2;
            cy1[n_iss] = eng_y1; cy2[n_iss] = eng_y2;
            n_iss++;
         end
         if (data_out_valid && n_out < 4) begin
            ocy[n_out] = cyc; oval[n_out] = data_out; n_out++;
         end
         if (in_ready === busy) viol++;
      end while (!(in_ready && !data_in_valid) && guard < 300);
      hist_clr = 1'b0;
      n_vec++;
      if (guard >= 300) begin n_miss++; $display("FAIL run_timeout got %0d cycles want <300", guard); end
   endtask

   task automatic check_reset_outputs(input string tag);
      n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL %s_in_ready got %b want 1", tag, in_ready); end
      n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL %s_busy got %b want 0", tag, busy); end
      n_vec++; if (eng_start !== 1'b0) begin n_miss++; $display("FAIL %s_eng_start got %b want 0", tag, eng_start); end
      n_vec++; if (eng_stage !== 3'd0) begin n_miss++; $display("FAIL %s_eng_stage got %0d want 0", tag, eng_stage); end
      n_vec++; if ({eng_x0, eng_x1, eng_x2, eng_y1, eng_y2} !== 80'd0) begin
         n_miss++; $display("FAIL %s_operands got %h want 0", tag, {eng_x0, eng_x1, eng_x2, eng_y1, eng_y2}); end
      n_vec++; if (data_out !== 16'h0) begin n_miss++; $display("FAIL %s_data_out got %h want 0000", tag, data_out); end
      n_vec++; if (data_out_valid !== 1'b0) begin n_miss++; $display("FAIL %s_dov got %b want 0", tag, data_out_valid); end
      n_vec++; if (err !== 1'b0) begin n_miss++; $display("FAIL %s_err got %b want 0", tag, err); end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; data_in = '0; data_in_valid = 1'b0; hist_clr = 1'b0; eng_mute = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("reset");
   endtask

   task automatic test_first_sample;
      logic [17:0] sg, se;
      bit ok;
      run(16'h4000, 1, 1'b0);
      n_vec++; if (n_out !== 1) begin n_miss++; $display("FAIL first_nout got %0d want 1", n_out); end
      n_vec++; if (oval[0] !== 16'h4000) begin n_miss++; $display("FAIL first_out got %h want 4000", oval[0]); end
      n_vec++; if (ocy[0] !== a + 19) begin n_miss++; $display("FAIL first_out_cyc got %0d want %0d", ocy[0] - a, 19); end
      n_vec++; if (n_iss !== N) begin n_miss++; $display("FAIL first_niss got %0d want %0d", n_iss, N); end
      sg = '0;
      for (int i = 0; i < N; i++) sg[i*3 +: 3] = stg[i];
      se = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
      n_vec++; if (sg !== se) begin n_miss++; $display("FAIL first_stage_seq got %h want %h", sg, se); end
      ok = 1'b1;
      for (int i = 0; i < N; i++) if (icy[i] != a + 1 + i * (L + 1)) ok = 1'b0;
      n_vec++; if (ok !== 1'b1) begin n_miss++; $display("FAIL first_issue_cycles got %0d want %0d", icy[N-1] - a, 1 + (N-1)*(L+1)); end
      n_vec++; if (data_out !== 16'h4000) begin n_miss++; $display("FAIL first_hold got %h want 4000", data_out); end
   endtask

   task automatic test_second_sample;
      run(16'h2000, 1, 1'b0);
      n_vec++; if ({cx0[0], cx1[0], cx2[0], cy1[0], cy2[0]} !== {16'h2000, 16'h4000, 16'h0, 16'h4000, 16'h0}) begin
         n_miss++; $display("FAIL second_sec0_ops got %h want 2000_4000_0000_4000_0000", {cx0[0], cx1[0], cx2[0], cy1[0], cy2[0]}); end
      n_vec++; if ({cx0[3], cx1[3], cy1[3]} !== {16'h2000, 16'h4000, 16'h4000}) begin
         n_miss++; $display("FAIL second_sec3_ops got %h want 2000_4000_4000", {cx0[3], cx1[3], cy1[3]}); end
      n_vec++; if (oval[0] !== 16'h2000) begin n_miss++; $display("FAIL second_out got %h want 2000", oval[0]); end
   endtask

   task automatic test_back_to_back;
      int s0;
      bit ok;
      run(16'h1000, 41, 1'b0);
      s0 = 0;
      for (int i = 0; i < n_iss; i++) if (stg[i] == 3'd0) s0++;
      n_vec++; if (s0 !== 3) begin n_miss++; $display("FAIL b2b_accepts got %0d want 3", s0); end
      n_vec++; if (n_iss !== 3 * N) begin n_miss++; $display("FAIL b2b_niss got %0d want %0d", n_iss, 3 * N); end
      n_vec++; if (n_out !== 3) begin n_miss++; $display("FAIL b2b_nout got %0d want 3", n_out); end
      ok = (n_out == 3);
      for (int i = 0; i < 3 && i < n_out; i++)
         if (ocy[i] != a + 19 + 20 * i || oval[i] != 16'h1000) ok = 1'b0;
      n_vec++; if (ok !== 1'b1) begin n_miss++; $display("FAIL b2b_outputs got %0d/%h want %0d/1000", ocy[0] - a, oval[0], 19); end
      n_vec++; if (viol !== 0) begin n_miss++; $display("FAIL b2b_ready_busy got %0d want 0", viol); end
   endtask

   task automatic test_hist_clr;
      run(16'h0800, 1, 1'b1);
      n_vec++; if (cx1[3] !== 16'h1000) begin n_miss++; $display("FAIL clr_busy_sec3_x1 got %h want 1000", cx1[3]); end
      run(16'h0400, 1, 1'b0);
      n_vec++; if ({cx1[0], cx2[0], cy1[0], cy2[0]} !== {16'h0800, 16'h1000, 16'h0800, 16'h1000}) begin
         n_miss++; $display("FAIL clr_busy_next_ops got %h want 0800_1000_0800_1000", {cx1[0], cx2[0], cy1[0], cy2[0]}); end
      @(negedge clk);
      hist_clr = 1'b1; data_in_valid = 1'b1; data_in = 16'h7777;
      @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL clr_priority_busy got %b want 0", busy); end
      n_vec++; if ({eng_x0, eng_y1} !== 32'd0) begin n_miss++; $display("FAIL clr_zero got %h want 0", {eng_x0, eng_y1}); end
      hist_clr = 1'b0; data_in_valid = 1'b0;
      run(16'h0C00, 1, 1'b0);
      n_vec++; if ({cx0[0], cx1[0], cx2[0], cy1[0], cy2[0]} !== {16'h0C00, 64'd0}) begin
         n_miss++; $display("FAIL clr_next_ops got %h want 0c00_0000_0000_0000_0000", {cx0[0], cx1[0], cx2[0], cy1[0], cy2[0]}); end
      n_vec++; if (oval[0] !== 16'h0C00) begin n_miss++; $display("FAIL clr_next_out got %h want 0c00", oval[0]); end
   endtask

   task automatic test_watchdog;
`ifdef OPTI_SCHED_WDOG_EN
      int a0, nv;
      logic [15:0] dprev;
      eng_mute = 1'b1; dprev = data_out; nv = 0;
      @(negedge clk);
      data_in = 16'h3000; data_in_valid = 1'b1; a0 = cyc;
      @(negedge clk);
      data_in_valid = 1'b0;
      while (cyc < a0 + 9) begin
         @(negedge clk);
         if (data_out_valid) nv++;
      end
      n_vec++; if ({err, busy} !== 2'b01) begin n_miss++; $display("FAIL wdog_early got err=%b busy=%b want err=0 busy=1", err, busy); end
      @(negedge clk);
      n_vec++; if ({err, in_ready} !== 2'b11) begin n_miss++; $display("FAIL wdog_trip got err=%b in_ready=%b want 1 1", err, in_ready); end
      n_vec++; if (nv !== 0) begin n_miss++; $display("FAIL wdog_no_output got %0d want 0", nv); end
      n_vec++; if (data_out !== dprev) begin n_miss++; $display("FAIL wdog_data_out got %h want %h", data_out, dprev); end
      eng_mute = 1'b0;
      run(16'h3800, 1, 1'b0);
      n_vec++; if ({cx1[0], cx2[0], cy1[0], cy2[0]} !== {16'h0C00, 16'h0, 16'h0C00, 16'h0}) begin
         n_miss++; $display("FAIL wdog_hist got %h want 0c00_0000_0c00_0000", {cx1[0], cx2[0], cy1[0], cy2[0]}); end
      n_vec++; if (oval[0] !== 16'h3800) begin n_miss++; $display("FAIL wdog_recover_out got %h want 3800", oval[0]); end
      n_vec++; if (err !== 1'b1) begin n_miss++; $display("FAIL wdog_sticky got %b want 1", err); end
      @(negedge clk); hist_clr = 1'b1;
      @(negedge clk); hist_clr = 1'b0;
      n_vec++; if (err !== 1'b0) begin n_miss++; $display("FAIL wdog_clr got %b want 0", err); end
`endif
   endtask

   task automatic test_reset_mid;
      int g;
      @(negedge clk);
      data_in = 16'h5000; data_in_valid = 1'b1;
      @(negedge clk);
      data_in_valid = 1'b0; g = 0;
      while (!(eng_start && eng_stage == 3'd3) && g < 100) begin @(negedge clk); g++; end
      n_vec++; if (g >= 100) begin n_miss++; $display("FAIL midrst_reach_sec3 got %0d cycles want <100", g); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      run(16'h4000, 1, 1'b0);
      n_vec++; if ({n_out, ocy[0] - a} !== {32'd1, 32'd19}) begin n_miss++; $display("FAIL midrst_timing got %0d/%0d want 1/19", n_out, ocy[0] - a); end
      n_vec++; if (oval[0] !== 16'h4000) begin n_miss++; $display("FAIL midrst_out got %h want 4000", oval[0]); end
      n_vec++; if ({cx1[0], cx2[0], cy1[0], cx1[3], cy1[3]} !== 80'd0) begin
         n_miss++; $display("FAIL midrst_hist got %h want 0", {cx1[0], cx2[0], cy1[0], cx1[3], cy1[3]}); end
   endtask

   initial begin
      test_reset;
      test_first_sample;
      test_second_sample;
      test_back_to_back;
      test_hist_clr;
      test_watchdog;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/opti_sos_scheduler.md
# opti_sos_scheduler

Time-multiplexing controller that runs all biquad sections of the IIR cascade on one shared SOS arithmetic engine instead of one engine per section. It accepts one Q2.14 sample at a time and issues one engine operation per section. For each operation it supplies the section index, which the engine uses for coefficient lookup, plus the direct-form-I history operands. It then collects the section result and emits the final cascade output. It sits between the input sample source and the output/address control, in place of a hard-wired section chain.

## Interface
Parameters:
- NUM_SECTIONS, 6, number of cascaded biquads (1..8).
- DW, 16, sample width, Q2.14.
- WDOG_CYCLES, 64, max cycles spent in WAIT (used only with watchdog compiled in).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  DW  input sample.
- data_in_valid  in  1  sample present.
- in_ready  out  1  scheduler can accept a sample.
- hist_clr  in  1  synchronous flush of all history; honored only in IDLE.
- eng_start  out  1  one-cycle engine launch pulse.
- eng_stage  out  3  section index for the engine's coefficient select.
- eng_x0, eng_x1, eng_x2  out  DW  section input: current, n-1, n-2.
- eng_y1, eng_y2  out  DW  section output history: n-1, n-2.
- eng_done  in  1  one-cycle pulse; eng_y valid in the same cycle.
- eng_y  in  DW  section result, already saturated to Q2.14.
- data_out  out  DW  cascade output.
- data_out_valid  out  1  one-cycle pulse.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky watchdog error.

## Operation
- Storage is three arrays indexed j = 0..NUM_SECTIONS:
  - cur[j]: value for the current sample.
  - h1[j]: value at n-1.
  - h2[j]: value at n-2.
  - j=0 is the cascade input; j=k+1 is the output of section k.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - hist_clr=1 zeroes h1, h2 and cur, and clears err. It takes priority over accepting a sample in the same cycle.
  - On data_in_valid && !hist_clr: cur[0]<=data_in, k<=0, go to ISSUE.
- ISSUE:
  - eng_start=1, eng_stage=k.
  - Operands: x0=cur[k], x1=h1[k], x2=h2[k], y1=h1[k+1], y2=h2[k+1].
  - Go to WAIT.
- WAIT:
  - Operands and eng_stage stay held.
  - On eng_done: cur[k+1]<=eng_y.
  - If k==NUM_SECTIONS-1 go to DONE; else k<=k+1 and go to ISSUE.
- DONE:
  - data_out<=cur[NUM_SECTIONS], data_out_valid=1.
  - All j shift together: h2[j]<=h1[j], h1[j]<=cur[j].
  - Go to IDLE.
- History shifts only in DONE, so later sections always see the unmodified n-1/n-2 outputs of earlier sections.
- No arithmetic is performed in the scheduler; widths pass through unchanged.
- Ignored inputs:
  - eng_done outside WAIT.
  - data_in_valid while in_ready=0 (no buffering; the source must hold the sample).
  - hist_clr outside IDLE.

## Timing
- Reset values:
  - state=IDLE, all arrays 0, k=0.
  - in_ready=1, busy=0, eng_start=0, eng_stage=0, all eng_* operands 0.
  - data_out=0, data_out_valid=0, err=0.
- Engine contract: eng_done arrives L≥1 cycles after eng_start.
- Cycle timing for a sample accepted at cycle a:
  - ISSUE of section k is at cycle a+1+k(L+1).
  - data_out_valid is at cycle a+1+N(L+1), where N=NUM_SECTIONS.
  - in_ready returns at a+2+N(L+1).
- Throughput: one sample per N(L+1)+2 cycles.
- data_out holds its value until the next DONE.
- Reset asserted mid-operation aborts immediately. The in-flight sample is lost, there is no output, and history is zeroed.

## Configuration
- OPTI_SCHED_WDOG_EN defined:
  - A counter runs in WAIT.
  - After WDOG_CYCLES cycles with no eng_done: err<=1 and the FSM returns to IDLE.
  - No output is produced and the history does not shift; cur values are discarded on the next accept.
  - err clears only on hist_clr or reset.
- OPTI_SCHED_WDOG_EN undefined:
  - WAIT waits indefinitely.
  - err is tied to 0 and the counter is absent.

## Structure
- Shared package opti_pkg holds:
  - NUM_SECTIONS and DW defaults.
  - The Q2.14 constants.
  - The FSM state enum.
- Sub-module opti_sched_hist holds the cur/h1/h2 register file. It has:
  - a write port for cur,
  - a shift-all strobe,
  - a clear,
  - a combinational operand read by k.

## Test plan
- Identity engine model (eng_y=eng_x0, L=2), N=6, input 0x4000 accepted at cycle a -> data_out=0x4000 with data_out_valid at a+19; eng_stage sequence 0..5.
- Second sample 0x2000 after the first -> at section 0 ISSUE: x0=0x2000, x1=0x4000, x2=0, y1=0x4000, y2=0. At section 3: x1=y1=0x4000.
- data_in_valid held high through the whole operation -> exactly one accept per in_ready window; no extra accepts while busy.
- hist_clr in IDLE after two samples -> all operands of the next sample's section 0 are 0 except x0; hist_clr while busy has no effect.
- OPTI_SCHED_WDOG_EN, WDOG_CYCLES=8, engine never asserts done -> err=1 after 8 WAIT cycles, FSM in IDLE, no data_out_valid, history unchanged.
- rst_n pulsed low during WAIT of section 3 -> all outputs at reset values immediately; the next sample behaves as the first after power-up.
